seq_max_ctrl: RTL and testbench

- Streaming controller that takes a burst of 4-bit sign-magnitude values over a valid/ready handshake and reports the maximum and the index where it first appeared.
- One comparator datapath is shared across all beats of the burst; this block sequences it beat by beat.
- Sits between a value source, such as a register-file read stream or testbench stimulus, and any consumer of the reduced result.

---
 rtl/seq_max_ctrl_if.sv | 27 ++
 rtl/seq_max_ctrl.sv | 118 +++++++++++
 tb/tb_seq_max_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_max_ctrl_if.sv
// Handshake and result bundle for seq_max_ctrl: burst control, beat stream and reduced result.
interface seq_max_ctrl_if #(
  parameter int DW   = 4,
  parameter int MAXN = 8,
  parameter int IDXW = 3
);
  logic            start;
  logic [IDXW:0]   len;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic            busy;
  logic            done;
  logic            empty;
  logic [DW-1:0]   max_val;
  logic [IDXW-1:0] max_idx;

  modport master (
    output start, len, in_valid, in_data,
    input  in_ready, busy, done, empty, max_val, max_idx
  );

  modport slave (
    input  start, len, in_valid, in_data,
    output in_ready, busy, done, empty, max_val, max_idx
  );
endinterface

// File: rtl/seq_max_ctrl.sv
// Burst max-reduction over sign-magnitude beats; one shared comparator,
// sequenced beat by beat, reporting the max and the index of its first occurrence.
module seq_max_ctrl #(
  parameter int DW   = 4,
  parameter int MAXN = 8,
  parameter int IDXW = 3
) (
  input  logic          clk,
  input  logic          reset,
  seq_max_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [IDXW:0] MAXN_L = (IDXW+1)'(MAXN);

  state_e          state_q, state_d;
  logic [IDXW:0]   count_q, count_d;
  logic [IDXW:0]   len_eff_q, len_eff_d;
  logic [DW-1:0]   max_val_q, max_val_d;
  logic [IDXW-1:0] max_idx_q, max_idx_d;
  logic            empty_q, empty_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [IDXW:0]   len_clamped;

  // Strict sign-magnitude greater-than; +0 ranks above -0, equal encodings are not greater.
  function automatic logic sm_gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic          sa, sb;
    logic [DW-2:0] ma, mb;
    sa = a[DW-1];
    sb = b[DW-1];
    ma = a[DW-2:0];
    mb = b[DW-2:0];
    if (a == b)          return 1'b0;
    else if (sa != sb)   return sb;
    else if (!sa)        return ma > mb;
    else                 return ma < mb;
  endfunction

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_eff_d   = len_eff_q;
    max_val_d   = max_val_q;
    max_idx_d   = max_idx_q;
    empty_d     = empty_q;
    len_clamped = (bus.len > MAXN_L) ? MAXN_L : bus.len;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_eff_d = len_clamped;
          count_d   = '0;
          empty_d   = 1'b0;
          if (len_clamped == '0) begin
            state_d   = DONE;
            empty_d   = 1'b1;
            max_val_d = '0;
            max_idx_d = '0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bus.in_valid) begin
          if (count_q == '0 || sm_gt(bus.in_data, max_val_q)) begin
            max_val_d = bus.in_data;
            max_idx_d = count_q[IDXW-1:0];
          end
          count_d = count_q + 1'b1;
          if (count_q == len_eff_q - 1'b1) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status outputs are registered by decoding the next state.
    in_ready_d = (state_d == RUN);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      len_eff_q  <= '0;
      max_val_q  <= '0;
      max_idx_q  <= '0;
      empty_q    <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      len_eff_q  <= len_eff_d;
      max_val_q  <= max_val_d;
      max_idx_q  <= max_idx_d;
      empty_q    <= empty_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.empty    = empty_q;
  assign bus.max_val  = max_val_q;
  assign bus.max_idx  = max_idx_q;

endmodule

// File: tb/tb_seq_max_ctrl.sv
// Scoreboard bench for seq_max_ctrl: expected results queued per burst, popped at done.
module tb_seq_max_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_max_ctrl_if #(.DW(4), .MAXN(8), .IDXW(3)) bus ();

  seq_max_ctrl #(.DW(4), .MAXN(8), .IDXW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] mv;
    logic [2:0] mi;
    logic       emp;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  logic [3:0] beat [0:15];

  logic       got_done;
  logic [3:0] o_mv;
  logic [2:0] o_mi;
  logic       o_emp;
  logic       o_busy;
  int         o_beats;
  int         o_cyc;

  // Rank: -7..-0 map to 0..7, +0..+7 map to 8..15.
  function automatic int rank(input logic [3:0] v);
    return v[3] ? 7 - int'(v[2:0]) : 8 + int'(v[2:0]);
  endfunction

  task automatic drive_burst(input int n, input bit stall, input bit hold_start, input bit skip_start);
    int   le;
    bit   acc;
    exp_t e;
    le    = (n > 8) ? 8 : n;
    e.mv  = '0;
    e.mi  = '0;
    e.emp = (le == 0);
    for (int i = 0; i < le; i++)
      if (i == 0 || rank(beat[i]) > rank(e.mv)) begin
        e.mv = beat[i];
        e.mi = i[2:0];
      end
    sb.push_back(e);
    got_done = 1'b0;
    o_beats  = 0;
    o_cyc    = 0;
    if (!skip_start) begin
      bus.start = 1'b1;
      bus.len   = n[3:0];
      @(negedge clk);
      o_cyc = 1;
      if (!hold_start) bus.start = 1'b0;
    end
    for (int t = 0; t < 200 && !got_done; t++) begin
      if (bus.done) begin
        got_done = 1'b1;
        o_mv     = bus.max_val;
        o_mi     = bus.max_idx;
        o_emp    = bus.empty;
        o_busy   = bus.busy;
      end else begin
        bus.in_valid = stall ? (t % 2 == 0) : 1'b1;
        bus.in_data  = bus.in_valid ? beat[o_beats & 15] : 4'($urandom);
        acc = bus.in_valid && bus.in_ready;
        @(negedge clk);
        o_cyc++;
        if (acc) o_beats++;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.in_ready, bus.busy, bus.done, bus.empty, bus.max_val, bus.max_idx} !== 11'b0) begin
      bad++;
      $display("FAIL reset_state got=%b want=0", {bus.in_ready, bus.busy, bus.done, bus.empty, bus.max_val, bus.max_idx});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mixed_tie();
    exp_t e;
    beat[0] = 4'b1101; beat[1] = 4'b0011; beat[2] = 4'b1001; beat[3] = 4'b0011;
    drive_burst(4, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    total++; if (!got_done)    begin bad++; $display("FAIL mixed_done got=0 want=1"); end
    total++; if (o_mv !== e.mv) begin bad++; $display("FAIL mixed_max got=%b want=%b", o_mv, e.mv); end
    total++; if (o_mi !== e.mi) begin bad++; $display("FAIL mixed_idx got=%0d want=%0d", o_mi, e.mi); end
    total++; if (o_cyc != 5)    begin bad++; $display("FAIL mixed_latency got=%0d want=5", o_cyc); end
    @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL mixed_done_pulse got=%b want=0", bus.done); end
  endtask

  task automatic test_all_negative();
    exp_t e;
    beat[0] = 4'b1111; beat[1] = 4'b1010; beat[2] = 4'b1100;
    drive_burst(3, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    total++; if (!got_done || o_mv !== e.mv || o_mi !== e.mi) begin
      bad++; $display("FAIL all_neg got=%b/%0d want=%b/%0d", o_mv, o_mi, e.mv, e.mi);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_signs();
    exp_t e;
    beat[0] = 4'b1000; beat[1] = 4'b0000;
    drive_burst(2, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    total++; if (!got_done || o_mv !== e.mv || o_mi !== e.mi) begin
      bad++; $display("FAIL zero_neg_first got=%b/%0d want=%b/%0d", o_mv, o_mi, e.mv, e.mi);
    end
    @(negedge clk);
    beat[0] = 4'b0000; beat[1] = 4'b1000;
    drive_burst(2, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    total++; if (!got_done || o_mv !== e.mv || o_mi !== e.mi) begin
      bad++; $display("FAIL zero_pos_first got=%b/%0d want=%b/%0d", o_mv, o_mi, e.mv, e.mi);
    end
    @(negedge clk);
  endtask

  task automatic test_empty();
    exp_t e;
    drive_burst(0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    total++; if (!got_done || o_cyc != 1) begin bad++; $display("FAIL empty_latency got=%0d done=%b want=1", o_cyc, got_done); end
    total++; if (o_emp !== e.emp || o_mv !== e.mv) begin
      bad++; $display("FAIL empty_result got=%b/%b want=%b/%b", o_emp, o_mv, e.emp, e.mv);
    end
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL empty_busy got=%b want=1", o_busy); end
    @(negedge clk);
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.empty !== 1'b1) begin
      bad++; $display("FAIL empty_after got=busy%b done%b empty%b want=busy0 done0 empty1", bus.busy, bus.done, bus.empty);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    beat[0] = 4'b0010; beat[1] = 4'b1111; beat[2] = 4'b0110; beat[3] = 4'b0001;
    beat[4] = 4'b0110; beat[5] = 4'b1000; beat[6] = 4'b0101; beat[7] = 4'b0000;
    beat[8] = 4'b0111;
    drive_burst(9, 1'b1, 1'b1, 1'b0);
    e = sb.pop_front();
    total++; if (o_beats != 8) begin bad++; $display("FAIL clamp_beats got=%0d want=8", o_beats); end
    total++; if (!got_done || o_mv !== e.mv || o_mi !== e.mi) begin
      bad++; $display("FAIL clamp_result got=%b/%0d want=%b/%0d", o_mv, o_mi, e.mv, e.mi);
    end
    @(negedge clk);
    total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL clamp_idle got=done%b busy%b want=done0 busy0", bus.done, bus.busy);
    end
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL held_start got=ready%b busy%b want=ready1 busy1", bus.in_ready, bus.busy);
    end
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) beat[i] = 4'b1000 | 4'(i);
    drive_burst(9, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front();
    total++; if (!got_done || o_beats != 8 || o_mv !== e.mv || o_mi !== e.mi) begin
      bad++; $display("FAIL second_burst got=%b/%0d beats=%0d want=%b/%0d beats=8", o_mv, o_mi, o_beats, e.mv, e.mi);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int dones;
    bus.start = 1'b1; bus.len = 4'd4;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 4'b0111; @(negedge clk);
    bus.in_data = 4'b0101; @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    total++;
    if ({bus.in_ready, bus.busy, bus.done, bus.max_val, bus.max_idx} !== 10'b0) begin
      bad++; $display("FAIL reset_mid_run got=%b want=0", {bus.in_ready, bus.busy, bus.done, bus.max_val, bus.max_idx});
    end
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    total++; if (dones != 0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_no_done got=dones%0d busy%b want=dones0 busy0", dones, bus.busy);
    end
  endtask

  task automatic test_random();
    exp_t e;
    int   n;
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(0, 10);
      for (int i = 0; i < 16; i++) beat[i] = 4'($urandom);
      drive_burst(n, 1'($urandom), 1'b0, 1'b0);
      e = sb.pop_front();
      total++;
      if (!got_done || o_mv !== e.mv || o_mi !== e.mi || o_emp !== e.emp || o_beats != ((n > 8) ? 8 : n)) begin
        bad++; $display("FAIL random_%0d len=%0d got=%b/%0d/%b beats=%0d want=%b/%0d/%b",
                        k, n, o_mv, o_mi, o_emp, o_beats, e.mv, e.mi, e.emp);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_mixed_tie();
    test_all_negative();
    test_zero_signs();
    test_empty();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
